// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Turns the byte stream from the PS/2 byte receiver into held-key levels and
// one-cycle key-event strobes for the game FSM, and exposes the last
// completed scan code for the HEX debug display.
//
// Set-2 prefixes are tracked:
//   E0 : extended key
//   F0 : break (key release)
//   E1 : start of the Pause sequence, which is skipped entirely
// If a multi-byte code stalls for TIMEOUT_CYCLES idle cycles, the partial
// code is abandoned.
//
// Ports
//   clk            system clock; the only clock in the block
//   reset          synchronous, active-low reset
//   byte_data      received scan-code byte; qualified by byte_valid
//   byte_valid     one-cycle strobe per received byte
//   ps2_key_data   final byte of the last completed code
//   key_event      one-cycle pulse per completed make or break code
//   key_break      1 = last event was a break, 0 = make; held until the next event
//   key_extended   1 = last completed code carried the E0 prefix
//   up/down/left/right/enter/space_pressed   held-key levels
//
// All outputs are registered. A byte strobed in cycle N shows its effect in
// cycle N+1.

module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic [7:0] ps2_key_data,
  output logic       key_event,
  output logic       key_break,
  output logic       key_extended,
  output logic       up_pressed,
  output logic       down_pressed,
  output logic       left_pressed,
  output logic       right_pressed,
  output logic       enter_pressed,
  output logic       space_pressed
);

  // Set-2 special bytes
  localparam logic [7:0] CODE_EXT      = 8'hE0;
  localparam logic [7:0] CODE_BRK      = 8'hF0;
  localparam logic [7:0] CODE_PAUSE    = 8'hE1;
  localparam logic [7:0] CODE_BAT_OK   = 8'hAA;
  localparam logic [7:0] CODE_BAT_FAIL = 8'hFC;

  // Game key codes
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  // After E1, seven more bytes belong to the Pause make sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // The idle counter only has to reach TIMEOUT_CYCLES-1, where it saturates
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Bit positions inside the held-key vector
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_ENTER = 4;
  localparam int K_SPACE = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t           state;
  state_t           state_next;
  state_t           eff_state;
  logic [2:0]       skip_cnt;
  logic [2:0]       skip_next;
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_hit;
  logic             is_prefix;

  logic             code_done;
  logic             code_break;
  logic             code_ext;
  logic             clear_levels;
  logic [5:0]       key_sel;
  logic [5:0]       held;

  // The timeout only matters while a code is partially received. A byte in
  // the same cycle always wins over the timeout.
  always_comb begin
    timeout_hit = (state != S_IDLE) && !byte_valid && (idle_cnt == CNT_LAST);
    is_prefix   = (byte_data == CODE_EXT) || (byte_data == CODE_BRK) ||
                  (byte_data == CODE_PAUSE);
  end

  // A prefix arriving after F0 abandons the pending break and starts over,
  // so that byte is decoded exactly as if the FSM were idle.
  always_comb begin
    eff_state = state;
    if (((state == S_BRK) || (state == S_EXT_BRK)) && is_prefix) begin
      eff_state = S_IDLE;
    end
  end

  // Next-state and per-byte decode
  always_comb begin
    state_next   = state;
    skip_next    = skip_cnt;
    code_done    = 1'b0;
    code_break   = 1'b0;
    code_ext     = 1'b0;
    clear_levels = 1'b0;

    if (byte_valid) begin
      case (eff_state)
        S_IDLE: begin
          case (byte_data)
            CODE_EXT: state_next = S_EXT;
            CODE_BRK: state_next = S_BRK;
            CODE_PAUSE: begin
              state_next = S_PAUSE;
              skip_next  = PAUSE_SKIP;
            end
            CODE_BAT_OK, CODE_BAT_FAIL: begin
              state_next   = S_IDLE;
              clear_levels = 1'b1;
            end
            default: begin
              state_next = S_IDLE;
              code_done  = 1'b1;
            end
          endcase
        end

        S_EXT: begin
          case (byte_data)
            CODE_BRK: state_next = S_EXT_BRK;
            CODE_EXT: state_next = S_EXT;
            default: begin
              state_next = S_IDLE;
              code_done  = 1'b1;
              code_ext   = 1'b1;
            end
          endcase
        end

        S_BRK: begin
          state_next = S_IDLE;
          code_done  = 1'b1;
          code_break = 1'b1;
        end

        S_EXT_BRK: begin
          state_next = S_IDLE;
          code_done  = 1'b1;
          code_break = 1'b1;
          code_ext   = 1'b1;
        end

        S_PAUSE: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_next = S_IDLE;
            skip_next  = 3'd0;
          end
        end

        default: begin
          state_next = S_IDLE;
          skip_next  = 3'd0;
        end
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
      skip_next  = 3'd0;
    end
  end

  // Which game key (if any) the completing code refers to. The extended
  // flag must match, so a bare 75 (keypad 8) does not touch the up key.
  always_comb begin
    key_sel = '0;
    if (code_ext) begin
      case (byte_data)
        CODE_UP:    key_sel[K_UP]    = 1'b1;
        CODE_DOWN:  key_sel[K_DOWN]  = 1'b1;
        CODE_LEFT:  key_sel[K_LEFT]  = 1'b1;
        CODE_RIGHT: key_sel[K_RIGHT] = 1'b1;
        default:    key_sel          = '0;
      endcase
    end else begin
      case (byte_data)
        CODE_ENTER: key_sel[K_ENTER] = 1'b1;
        CODE_SPACE: key_sel[K_SPACE] = 1'b1;
        default:    key_sel          = '0;
      endcase
    end
  end

  // FSM state, pause skip counter and idle counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      if (byte_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != CNT_LAST) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // Registered outputs. Held levels change in the same cycle key_event
  // asserts; a typematic repeat re-sets an already-set level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps2_key_data <= 8'h00;
      key_event    <= 1'b0;
      key_break    <= 1'b0;
      key_extended <= 1'b0;
      held         <= '0;
    end else begin
      key_event <= code_done;
      if (code_done) begin
        ps2_key_data <= byte_data;
        key_break    <= code_break;
        key_extended <= code_ext;
        if (code_break) begin
          held <= held & ~key_sel;
        end else begin
          held <= held | key_sel;
        end
      end else if (clear_levels) begin
        held <= '0;
      end
    end
  end

  always_comb begin
    up_pressed    = held[K_UP];
    down_pressed  = held[K_DOWN];
    left_pressed  = held[K_LEFT];
    right_pressed = held[K_RIGHT];
    enter_pressed = held[K_ENTER];
    space_pressed = held[K_SPACE];
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder.
//
// A flag-based reference model (pending-extended, pending-break, bytes left
// to skip, idle cycles since the last byte) predicts every output after each
// clock. Directed scenarios come first, followed by a random byte stream
// with random gaps, some of them around the timeout length.

module tb_ps2_scancode_decoder;

  localparam int T = 16;

  logic       clk;
  logic       reset;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] ps2_key_data;
  logic       key_event;
  logic       key_break;
  logic       key_extended;
  logic       up_pressed;
  logic       down_pressed;
  logic       left_pressed;
  logic       right_pressed;
  logic       enter_pressed;
  logic       space_pressed;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model state
  bit         m_ext;
  bit         m_brk;
  int         m_pause;
  int         m_gap;
  logic       e_event;
  logic [7:0] e_data;
  logic       e_break;
  logic       e_ext;
  logic [5:0] e_held;  // {space, enter, right, left, down, up}

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .ps2_key_data  (ps2_key_data),
    .key_event     (key_event),
    .key_break     (key_break),
    .key_extended  (key_extended),
    .up_pressed    (up_pressed),
    .down_pressed  (down_pressed),
    .left_pressed  (left_pressed),
    .right_pressed (right_pressed),
    .enter_pressed (enter_pressed),
    .space_pressed (space_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game key table: which held bit a completed code refers to
  function automatic logic [5:0] keyMask(bit ext, logic [7:0] b);
    logic [5:0] m;
    m = 6'b0;
    if (ext) begin
      if (b == 8'h75) m = 6'b000001;
      if (b == 8'h72) m = 6'b000010;
      if (b == 8'h6B) m = 6'b000100;
      if (b == 8'h74) m = 6'b001000;
    end else begin
      if (b == 8'h5A) m = 6'b010000;
      if (b == 8'h29) m = 6'b100000;
    end
    return m;
  endfunction

  task automatic modelReset();
    m_ext   = 0;
    m_brk   = 0;
    m_pause = 0;
    m_gap   = 0;
    e_event = 1'b0;
    e_data  = 8'h00;
    e_break = 1'b0;
    e_ext   = 1'b0;
    e_held  = 6'b0;
  endtask

  task automatic modelComplete(bit brk, bit ext, logic [7:0] b);
    e_event = 1'b1;
    e_data  = b;
    e_break = brk;
    e_ext   = ext;
    if (brk) e_held = e_held & ~keyMask(ext, b);
    else     e_held = e_held | keyMask(ext, b);
    m_ext = 0;
    m_brk = 0;
  endtask

  // One clock of the reference model
  task automatic modelStep(logic valid, logic [7:0] b);
    bit pfx;
    e_event = 1'b0;
    if (!valid) begin
      m_gap++;
      return;
    end
    if (m_gap >= T) begin
      m_ext   = 0;
      m_brk   = 0;
      m_pause = 0;
    end
    m_gap = 0;
    if (m_pause > 0) begin
      m_pause--;
      return;
    end
    pfx = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    if (m_brk && pfx) begin
      m_ext = 0;
      m_brk = 0;
    end
    if (m_brk) begin
      modelComplete(1, m_ext, b);
    end else if (m_ext) begin
      if (b == 8'hF0)      m_brk = 1;
      else if (b != 8'hE0) modelComplete(0, 1, b);
    end else begin
      if (b == 8'hE0)                      m_ext = 1;
      else if (b == 8'hF0)                 m_brk = 1;
      else if (b == 8'hE1)                 m_pause = 7;
      else if (b == 8'hAA || b == 8'hFC)   e_held = 6'b0;
      else                                 modelComplete(0, 0, b);
    end
  endtask

  task automatic checkOne(string name, logic [7:0] obs, logic [7:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkOne({tag, ".key_event"},    {7'b0, key_event},    {7'b0, e_event});
    checkOne({tag, ".ps2_key_data"}, ps2_key_data,         e_data);
    checkOne({tag, ".key_break"},    {7'b0, key_break},    {7'b0, e_break});
    checkOne({tag, ".key_extended"}, {7'b0, key_extended}, {7'b0, e_ext});
    checkOne({tag, ".levels"},
             {2'b0, space_pressed, enter_pressed, right_pressed,
              left_pressed, down_pressed, up_pressed},
             {2'b0, e_held});
  endtask

  // Drive one clock with the given byte strobe, then check outputs
  task automatic applyStimulus(logic valid, logic [7:0] b, string tag);
    @(negedge clk);
    byte_valid = valid;
    byte_data  = valid ? b : 8'($urandom);
    @(posedge clk);
    #1;
    modelStep(valid, b);
    checkOutput(tag);
  endtask

  task automatic sendByte(logic [7:0] b, string tag);
    applyStimulus(1'b1, b, tag);
  endtask

  task automatic idleCycles(int n, string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, tag);
  endtask

  // Reset cycles; a byte strobed during reset must be discarded
  task automatic resetCycles(int n, string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset      = 1'b0;
      byte_valid = 1'b1;
      byte_data  = 8'h29;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput(tag);
    end
    @(negedge clk);
    reset      = 1'b1;
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] pool [12];
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h29, 8'h5A, 8'h75,
             8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFC, 8'h1C};
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    modelReset();

    $display("[TB] scenario 1: reset, space make/break");
    resetCycles(3, "reset");
    sendByte(8'h29, "space_make");
    idleCycles(1, "space_make_idle");
    sendByte(8'hF0, "space_f0");
    sendByte(8'h29, "space_break");
    idleCycles(1, "space_break_idle");

    $display("[TB] scenario 2: extended up vs keypad 8");
    sendByte(8'hE0, "up_e0");
    sendByte(8'h75, "up_make");
    sendByte(8'h75, "kp8_make");
    sendByte(8'hE0, "up_brk_e0");
    sendByte(8'hF0, "up_brk_f0");
    sendByte(8'h75, "up_break");

    $display("[TB] scenario 3: pause sequence skipped");
    sendByte(8'hE1, "pause0");
    sendByte(8'h14, "pause1");
    sendByte(8'h77, "pause2");
    sendByte(8'hE1, "pause3");
    sendByte(8'hF0, "pause4");
    sendByte(8'h14, "pause5");
    sendByte(8'hF0, "pause6");
    sendByte(8'h77, "pause7");
    sendByte(8'h5A, "enter_make");

    $display("[TB] scenario 4: timeout boundary");
    sendByte(8'hE0, "to_e0");
    idleCycles(T, "to_gap16");
    sendByte(8'h74, "to_74_plain");
    sendByte(8'hE0, "nto_e0");
    idleCycles(T - 1, "nto_gap15");
    sendByte(8'h74, "nto_right_make");

    $display("[TB] scenario 5: self-test clears levels");
    sendByte(8'hE0, "p_e0a");
    sendByte(8'h6B, "p_left");
    sendByte(8'hE0, "p_e0b");
    sendByte(8'h72, "p_down");
    sendByte(8'h29, "p_space");
    sendByte(8'hAA, "bat_aa");
    idleCycles(1, "bat_idle");

    $display("[TB] scenario 6: reset mid-sequence");
    sendByte(8'hE0, "mid_e0");
    sendByte(8'hF0, "mid_f0");
    resetCycles(1, "mid_reset");
    sendByte(8'h6B, "mid_6b");
    sendByte(8'hF0, "brk_then_e0_f0");
    sendByte(8'hE0, "brk_then_e0");
    sendByte(8'h6B, "brk_dropped_left");

    $display("[TB] random phase");
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      int gap;
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else                           b = pool[$urandom_range(0, 11)];
      sendByte(b, "rand_byte");
      if ($urandom_range(0, 7) == 0) gap = $urandom_range(T - 2, T + 2);
      else                           gap = $urandom_range(0, 2);
      idleCycles(gap, "rand_gap");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
